// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared VGA 640x480@60 timing constants, derived totals and the
//           per-axis phase encoding.
// Revision: 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Counter and output widths
  localparam int CNT_W = 10;
  localparam int COL_W = 10;
  localparam int ROW_W = 9;

  // Horizontal timing, in pixel clocks
  localparam int C_H_ACTIVE = 640;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 96;
  localparam int C_H_BP     = 48;
  localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;

  // Vertical timing, in lines
  localparam int C_V_ACTIVE = 480;
  localparam int C_V_FP     = 10;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 33;
  localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;

  // Region an axis counter currently sits in
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

endpackage
`default_nettype wire

// File: rtl/vga_axis_timer.sv
`default_nettype none
// ============================================================================
// Module  : vga_axis_timer
// Purpose : One timing axis: a wrapping counter plus a phase tracker that
//           always names the region the counter is in.
// Revision: 1.0 - initial release
// ============================================================================
module vga_axis_timer
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = C_H_ACTIVE,
  parameter int FP_LEN     = C_H_FP,
  parameter int SYNC_LEN   = C_H_SYNC,
  parameter int BP_LEN     = C_H_BP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output phase_t           phase,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  // Last count value of each region; the phase moves on when leaving it
  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(ACTIVE_LEN + FP_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TOTAL  = CNT_W'(TOTAL - 1);

  phase_t phase_nxt;

  // Wrap fires on the enabled step out of the final count
  assign wrap = enable && (cnt == LAST_TOTAL);

  // Phase that matches the count value after the next enabled step
  always_comb begin
    phase_nxt = phase;
    if (cnt == LAST_ACTIVE) begin
      phase_nxt = FRONT;
    end else if (cnt == LAST_FRONT) begin
      phase_nxt = SYNC;
    end else if (cnt == LAST_SYNC) begin
      phase_nxt = BACK;
    end else if (cnt == LAST_TOTAL) begin
      phase_nxt = ACTIVE;
    end
  end

  // Counter and phase advance together so they can never disagree
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= ACTIVE;
    end else if (enable) begin
      cnt   <= wrap ? '0 : cnt + 1'b1;
      phase <= phase_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Purpose : VGA sync/blank generator. Two axis timers (pixel and line) feed a
//           single output register stage, so every output lags the counters
//           by one clock.
// Revision: 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic             h_sync,
  output logic             v_sync,
  output logic             disp_ena,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             n_blank,
  output logic             n_sync,
  output logic             frame_start
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  phase_t           h_phase;
  phase_t           v_phase;
  logic             h_wrap;
  logic             v_wrap;
  logic             disp_nxt;
  logic             sof_pending;

  // Pixel axis steps every clock
  vga_axis_timer #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP)
  ) u_h_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .cnt    (h_cnt),
    .phase  (h_phase),
    .wrap   (h_wrap)
  );

  // Line axis steps once per line, on the pixel wrap
  vga_axis_timer #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP)
  ) u_v_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (h_wrap),
    .cnt    (v_cnt),
    .phase  (v_phase),
    .wrap   (v_wrap)
  );

  assign disp_nxt = (h_phase == ACTIVE) && (v_phase == ACTIVE);

  // DAC blank follows the display enable; composite sync is not used
  assign n_blank = disp_ena;
  assign n_sync  = 1'b0;

  // Output stage; sof_pending is set whenever the counters are at (0,0),
  // i.e. straight out of reset and right after the frame wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      disp_ena    <= 1'b0;
      col         <= '0;
      row         <= '0;
      frame_start <= 1'b0;
      sof_pending <= 1'b1;
    end else begin
      h_sync      <= (h_phase != SYNC);
      v_sync      <= (v_phase != SYNC);
      disp_ena    <= disp_nxt;
      col         <= disp_nxt ? COL_W'(h_cnt) : '0;
      row         <= disp_nxt ? ROW_W'(v_cnt) : '0;
      frame_start <= sof_pending;
      sof_pending <= v_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_gen
// Purpose : Self-checking bench. Instance A uses the standard 640x480 timing,
//           instance B a shrunken timing so whole frames fit in a short run.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] col;
    logic [8:0] row;
    logic       fs;
    logic       nb;
    logic       ns;
  } out_t;

  typedef struct {
    int   n;
    out_t exp;
  } vec_t;

  // Standard timing (instance A)
  localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam int AHT = AHA + AHF + AHS + AHB;
  localparam int AVT = AVA + AVF + AVS + AVB;
  // Shrunken timing (instance B): 25 clocks/line, 17 lines/frame
  localparam int BHA = 16, BHF = 2, BHS = 4, BHB = 3;
  localparam int BVA = 10, BVF = 2, BVS = 2, BVB = 3;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;
  localparam int BFT = BHT * BVT;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       hs_a, vs_a, de_a, nb_a, ns_a, fs_a;
  logic [9:0] col_a;
  logic [8:0] row_a;
  logic       hs_b, vs_b, de_b, nb_b, ns_b, fs_b;
  logic [9:0] col_b;
  logic [8:0] row_b;
  out_t       out_a, out_b;

  assign out_a = {hs_a, vs_a, de_a, col_a, row_a, fs_a, nb_a, ns_a};
  assign out_b = {hs_b, vs_b, de_b, col_b, row_b, fs_b, nb_b, ns_b};

  vga_timing_gen u_dut_a (
    .clk (clk), .reset (reset),
    .h_sync (hs_a), .v_sync (vs_a), .disp_ena (de_a),
    .col (col_a), .row (row_a), .n_blank (nb_a), .n_sync (ns_a),
    .frame_start (fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (BHA), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
    .V_ACTIVE (BVA), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB)
  ) u_dut_b (
    .clk (clk), .reset (reset),
    .h_sync (hs_b), .v_sync (vs_b), .disp_ena (de_b),
    .col (col_b), .row (row_b), .n_blank (nb_b), .n_sync (ns_b),
    .frame_start (fs_b)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   ha = 0, va = 0, hb = 0, vb = 0;
  out_t q_a[$];
  out_t q_b[$];
  vec_t tbl[10];

  function automatic out_t mk(logic hs, logic vs, logic de, int c, int r, logic fs);
    out_t o;
    o.hs  = hs;
    o.vs  = vs;
    o.de  = de;
    o.col = 10'(c);
    o.row = 9'(r);
    o.fs  = fs;
    o.nb  = de;
    o.ns  = 1'b0;
    return o;
  endfunction

  // Expected registered outputs for a counter position, from region bounds
  function automatic out_t model(int h, int v, int hact, int hfp, int hsy,
                                 int vact, int vfp, int vsy);
    logic de;
    de = (h < hact) && (v < vact);
    return mk(!(h >= hact + hfp && h < hact + hfp + hsy),
              !(v >= vact + vfp && v < vact + vfp + vsy),
              de, de ? h : 0, de ? v : 0, (h == 0) && (v == 0));
  endfunction

  task automatic check_out(string name, out_t act, out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic adv(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  // One clock: push expectations, clock, advance model, pop and compare
  task automatic step();
    if (reset) begin
      q_a.push_back(mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0));
      q_b.push_back(mk(1'b1, 1'b1, 1'b0, 0, 0, 1'b0));
    end else begin
      q_a.push_back(model(ha, va, AHA, AHF, AHS, AVA, AVF, AVS));
      q_b.push_back(model(hb, vb, BHA, BHF, BHS, BVA, BVF, BVS));
    end
    @(posedge clk);
    if (!reset) begin
      adv(ha, va, AHT, AVT);
      adv(hb, vb, BHT, BVT);
    end
    @(negedge clk);
    if (q_a.size() == 0 || q_b.size() == 0) begin
      check_int("sb_queue_empty", 0, 1);
    end else begin
      check_out("sb_a", out_a, q_a.pop_front());
      check_out("sb_b", out_b, q_b.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ha = 0; va = 0; hb = 0; vb = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no end required end");
    $fatal(1, "timeout");
  end

  initial begin
    int hs_low, hs_first, de_low;
    int vs_low, vs_first, de_hi, fs_cnt, fs_first, fs_second;
    int last_de, first_de_after, row_last, col_last;

    // Edge count after release -> expected standard-timing outputs
    tbl[0] = '{1,    mk(1, 1, 1, 0,   0, 1)};
    tbl[1] = '{2,    mk(1, 1, 1, 1,   0, 0)};
    tbl[2] = '{640,  mk(1, 1, 1, 639, 0, 0)};
    tbl[3] = '{641,  mk(1, 1, 0, 0,   0, 0)};
    tbl[4] = '{656,  mk(1, 1, 0, 0,   0, 0)};
    tbl[5] = '{657,  mk(0, 1, 0, 0,   0, 0)};
    tbl[6] = '{752,  mk(0, 1, 0, 0,   0, 0)};
    tbl[7] = '{753,  mk(1, 1, 0, 0,   0, 0)};
    tbl[8] = '{801,  mk(1, 1, 1, 0,   1, 0)};
    tbl[9] = '{1440, mk(1, 1, 1, 639, 1, 0)};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      repeat (tbl[i].n) step();
      check_out($sformatf("vec%0d_n%0d", i, tbl[i].n), out_a, tbl[i].exp);
    end

    // One standard line: sync width/position and blanking length
    do_reset();
    hs_low = 0; hs_first = -1; de_low = 0;
    for (int k = 0; k < AHT; k++) begin
      step();
      if (!out_a.hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (!out_a.de) de_low++;
    end
    check_int("line_hsync_low", hs_low, 96);
    check_int("line_hsync_fall", hs_first, 656);
    check_int("line_blank_len", de_low, 160);

    // Two shrunken frames: vsync, visible count, frame period
    do_reset();
    vs_low = 0; vs_first = -1; de_hi = 0; fs_cnt = 0;
    fs_first = -1; fs_second = -1; last_de = -1; first_de_after = -1;
    row_last = -1; col_last = -1;
    for (int k = 0; k <= 2 * BFT; k++) begin
      step();
      if (out_b.fs) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (k < BFT) begin
        if (!out_b.vs) begin
          vs_low++;
          if (vs_first < 0) vs_first = k;
        end
        if (out_b.de) begin
          de_hi++;
          last_de  = k;
          row_last = int'(out_b.row);
          col_last = int'(out_b.col);
        end
        if (out_b.fs) fs_cnt++;
      end else if (out_b.de && first_de_after < 0) begin
        first_de_after = k;
      end
    end
    check_int("frame_vsync_low", vs_low, BVS * BHT);
    check_int("frame_vsync_start", vs_first, (BVA + BVF) * BHT);
    check_int("frame_visible", de_hi, BHA * BVA);
    check_int("frame_fs_count", fs_cnt, 1);
    check_int("frame_fs_first", fs_first, 0);
    check_int("frame_period", fs_second - fs_first, BFT);
    check_int("frame_last_vis", last_de, (BVA - 1) * BHT + BHA - 1);
    check_int("frame_last_row", row_last, BVA - 1);
    check_int("frame_last_col", col_last, BHA - 1);
    check_int("frame_next_vis", first_de_after, BFT);

    // Async reset while both syncs of B are low (h=20, v=13)
    do_reset();
    repeat (13 * BHT + 20 + 1) step();
    check_int("pre_rst_hsync", int'(out_b.hs), 0);
    check_int("pre_rst_vsync", int'(out_b.vs), 0);
    #2;
    reset = 1'b1;
    ha = 0; va = 0; hb = 0; vb = 0;
    #1;
    check_out("async_rst_b", out_b, mk(1, 1, 0, 0, 0, 0));
    check_out("async_rst_a", out_a, mk(1, 1, 0, 0, 0, 0));
    step();
    reset = 1'b0;
    step();
    check_out("rerelease_b", out_b, mk(1, 1, 1, 0, 0, 1));
    check_out("rerelease_a", out_a, mk(1, 1, 1, 0, 0, 1));
    repeat (639) step();
    check_out("rerelease_a_col639", out_a, mk(1, 1, 1, 639, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
